// File: rtl/stream_mux_pkg.sv
// Shared constants and helpers for the stream multiplexer/arbiter slice.
package stream_mux_pkg;

  localparam int MODE_RR    = 0;
  localparam int MODE_FIXED = 1;
  localparam int MODE_EXT   = 2;

  // Index width that never collapses to zero bits, even for tiny channel counts.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: first requester at or above ptr wins, wrapping around.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int NCH = 4,
  localparam int SELW = clog2_min1(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] grant,
  output logic            grant_valid
);

  logic [2*NCH-1:0] dbl;

  // Doubling the request vector turns the wrap-around search into a plain
  // lowest-set-bit search over positions at or above ptr.
  always_comb begin
    dbl         = {req, req};
    grant       = '0;
    grant_valid = 1'b0;
    for (int j = 0; j < 2*NCH; j++) begin
      if (!grant_valid && dbl[j] && (j >= int'(ptr))) begin
        grant_valid = 1'b1;
        grant       = (j >= NCH) ? SELW'(j - NCH) : SELW'(j);
      end
    end
  end

endmodule

// File: rtl/stream_mux_arb.sv
// N-channel stream multiplexer with selectable arbitration and a registered output stage.
module stream_mux_arb
  import stream_mux_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int NCH   = 4,
  parameter int MODE  = MODE_RR,
  localparam int SELW = clog2_min1(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       in_valid,
  input  logic [NCH*WIDTH-1:0] in_data,
  output logic [NCH-1:0]       in_ready,
  input  logic [SELW-1:0]      sel_ext,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_ch,
  input  logic                 out_ready
);

  // Handshake: a beat transfers on any cycle where valid && ready are both high.
  // in_ready is a function of out_ready (via load) and the grant, never of the
  // channel's own valid beyond the grant; out_data/out_ch are stable while stalled.

  logic             load;
  logic [SELW-1:0]  ptr_q;
  logic [SELW-1:0]  arb_ptr;
  logic [SELW-1:0]  arb_grant;
  logic             arb_valid;
  logic             ext_valid;
  logic [SELW-1:0]  grant;
  logic             grant_valid;
  logic [WIDTH-1:0] grant_data;

  assign load    = !out_valid || out_ready;
  assign arb_ptr = (MODE == MODE_RR) ? ptr_q : '0;

  rr_arbiter #(.NCH(NCH)) u_arb (
    .req         (in_valid),
    .ptr         (arb_ptr),
    .grant       (arb_grant),
    .grant_valid (arb_valid)
  );

  // Out-of-range selects simply match no channel, so they yield no grant.
  always_comb begin
    ext_valid = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (sel_ext == SELW'(k)) ext_valid = in_valid[k];
    end
  end

  always_comb begin
    grant       = arb_grant;
    grant_valid = arb_valid;
    if (MODE == MODE_EXT) begin
      grant       = sel_ext;
      grant_valid = ext_valid;
    end
  end

  always_comb begin
    grant_data = '0;
    in_ready   = '0;
    for (int k = 0; k < NCH; k++) begin
      if (grant == SELW'(k)) begin
        grant_data  = in_data[k*WIDTH +: WIDTH];
        in_ready[k] = load && grant_valid;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else if (load) begin
      out_valid <= grant_valid;
      if (grant_valid) begin
        out_data <= grant_data;
        out_ch   <= grant;
      end
    end
  end

  // Pointer only moves in round-robin mode and only on an accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if ((MODE == MODE_RR) && load && grant_valid) begin
      ptr_q <= (grant == SELW'(NCH - 1)) ? '0 : grant + SELW'(1);
    end
  end

endmodule

// File: tb/tb_stream_mux_arb.sv
// Directed bench for stream_mux_arb covering round-robin, fixed, and external-select modes.
module tb_stream_mux_arb;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // {ch, data} per expected beat, one queue per instance
  logic [3:0] exp_q_rr[$];
  logic [3:0] exp_q_fx[$];
  logic [3:0] exp_q_ex[$];
  logic [3:0] exp_q_e3[$];

  logic [3:0] rr_valid = '0, fx_valid = '0, ex_valid = '0;
  logic [7:0] rr_data = '0, fx_data = '0, ex_data = '0;
  logic [3:0] rr_rdy, fx_rdy, ex_rdy;
  logic [1:0] rr_sel = '0, fx_sel = '0, ex_sel = '0;
  logic       rr_ov, fx_ov, ex_ov;
  logic [1:0] rr_od, fx_od, ex_od;
  logic [1:0] rr_och, fx_och, ex_och;
  logic       rr_or = 1'b0, fx_or = 1'b0, ex_or = 1'b0;

  logic [2:0] e3_valid = '0;
  logic [5:0] e3_data = '0;
  logic [2:0] e3_rdy;
  logic [1:0] e3_sel = '0;
  logic       e3_ov;
  logic [1:0] e3_od, e3_och;
  logic       e3_or = 1'b0;

  stream_mux_arb #(.WIDTH(2), .NCH(4), .MODE(0)) u_rr (
    .clk(clk), .rst_n(rst_n), .in_valid(rr_valid), .in_data(rr_data), .in_ready(rr_rdy),
    .sel_ext(rr_sel), .out_valid(rr_ov), .out_data(rr_od), .out_ch(rr_och), .out_ready(rr_or));
  stream_mux_arb #(.WIDTH(2), .NCH(4), .MODE(1)) u_fx (
    .clk(clk), .rst_n(rst_n), .in_valid(fx_valid), .in_data(fx_data), .in_ready(fx_rdy),
    .sel_ext(fx_sel), .out_valid(fx_ov), .out_data(fx_od), .out_ch(fx_och), .out_ready(fx_or));
  stream_mux_arb #(.WIDTH(2), .NCH(4), .MODE(2)) u_ex (
    .clk(clk), .rst_n(rst_n), .in_valid(ex_valid), .in_data(ex_data), .in_ready(ex_rdy),
    .sel_ext(ex_sel), .out_valid(ex_ov), .out_data(ex_od), .out_ch(ex_och), .out_ready(ex_or));
  stream_mux_arb #(.WIDTH(2), .NCH(3), .MODE(2)) u_e3 (
    .clk(clk), .rst_n(rst_n), .in_valid(e3_valid), .in_data(e3_data), .in_ready(e3_rdy),
    .sel_ext(e3_sel), .out_valid(e3_ov), .out_data(e3_od), .out_ch(e3_och), .out_ready(e3_or));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitors: pop and compare on every output handshake
  always @(negedge clk) begin
    if (rst_n && rr_ov && rr_or) begin
      if (exp_q_rr.size() == 0) chk("rr_unexpected_beat", {28'd0, rr_och, rr_od}, 32'hffff);
      else chk("rr_beat", {28'd0, rr_och, rr_od}, {28'd0, exp_q_rr.pop_front()});
    end
  end
  always @(negedge clk) begin
    if (rst_n && fx_ov && fx_or) begin
      if (exp_q_fx.size() == 0) chk("fx_unexpected_beat", {28'd0, fx_och, fx_od}, 32'hffff);
      else chk("fx_beat", {28'd0, fx_och, fx_od}, {28'd0, exp_q_fx.pop_front()});
    end
  end
  always @(negedge clk) begin
    if (rst_n && ex_ov && ex_or) begin
      if (exp_q_ex.size() == 0) chk("ex_unexpected_beat", {28'd0, ex_och, ex_od}, 32'hffff);
      else chk("ex_beat", {28'd0, ex_och, ex_od}, {28'd0, exp_q_ex.pop_front()});
    end
  end
  always @(negedge clk) begin
    if (rst_n && e3_ov && e3_or) begin
      if (exp_q_e3.size() == 0) chk("e3_unexpected_beat", {28'd0, e3_och, e3_od}, 32'hffff);
      else chk("e3_beat", {28'd0, e3_och, e3_od}, {28'd0, exp_q_e3.pop_front()});
    end
  end

  initial begin
    // Reset and idle
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", {31'd0, rr_ov}, 32'd0);
    chk("reset_out_data", {30'd0, rr_od}, 32'd0);
    chk("reset_out_ch", {30'd0, rr_och}, 32'd0);
    rst_n = 1'b1;
    #1 chk("idle_in_ready", {28'd0, rr_rdy}, 32'd0);
    tick;

    // Round-robin rotation
    rr_data = 8'b11_10_01_00;
    rr_or = 1'b1;
    exp_q_rr.push_back(4'h0); exp_q_rr.push_back(4'h5); exp_q_rr.push_back(4'ha);
    exp_q_rr.push_back(4'hf); exp_q_rr.push_back(4'h0);
    rr_valid = 4'hf;
    for (int i = 0; i < 5; i++) begin
      #1 chk("rr_rot_in_ready", {28'd0, rr_rdy}, 32'd1 << (i % 4));
      tick;
      chk("rr_rot_out_valid", {31'd0, rr_ov}, 32'd1);
      chk("rr_rot_out_ch", {30'd0, rr_och}, i % 4);
    end
    rr_valid = 4'h0;
    tick;
    chk("rr_drained", {31'd0, rr_ov}, 32'd0);

    // Backpressure: pointer is now at channel 1
    exp_q_rr.push_back(4'h5); exp_q_rr.push_back(4'ha); exp_q_rr.push_back(4'hf);
    rr_valid = 4'hf;
    #1 chk("rr_bp_in_ready", {28'd0, rr_rdy}, 32'h2);
    tick;
    rr_or = 1'b0;
    repeat (3) begin
      #1 chk("rr_stall_in_ready", {28'd0, rr_rdy}, 32'd0);
      chk("rr_stall_out_ch", {30'd0, rr_och}, 32'd1);
      chk("rr_stall_out_data", {30'd0, rr_od}, 32'd1);
      chk("rr_stall_out_valid", {31'd0, rr_ov}, 32'd1);
      tick;
    end
    rr_or = 1'b1;
    #1 chk("rr_release_in_ready", {28'd0, rr_rdy}, 32'h4);
    tick;
    chk("rr_release_out_ch", {30'd0, rr_och}, 32'd2);
    chk("rr_release_out_valid", {31'd0, rr_ov}, 32'd1);
    tick;
    tick;
    // Channel 0 beat is now in flight; reset drops it asynchronously
    rst_n = 1'b0;
    #1 chk("midreset_out_valid", {31'd0, rr_ov}, 32'd0);
    chk("midreset_out_data", {30'd0, rr_od}, 32'd0);
    chk("midreset_out_ch", {30'd0, rr_och}, 32'd0);
    tick;
    rst_n = 1'b1;
    #1 chk("rr_ptr_after_reset", {28'd0, rr_rdy}, 32'h1);
    rr_valid = 4'h0;
    tick;
    chk("rr_idle_after_reset", {31'd0, rr_ov}, 32'd0);

    // Fixed priority
    fx_data = 8'b11_10_01_00;
    fx_or = 1'b1;
    exp_q_fx.push_back(4'h5); exp_q_fx.push_back(4'h5); exp_q_fx.push_back(4'h5);
    exp_q_fx.push_back(4'hf);
    fx_valid = 4'b1010;
    repeat (3) begin
      #1 chk("fx_prio_in_ready", {28'd0, fx_rdy}, 32'h2);
      tick;
      chk("fx_prio_out_ch", {30'd0, fx_och}, 32'd1);
    end
    fx_valid = 4'b1000;
    #1 chk("fx_ch3_in_ready", {28'd0, fx_rdy}, 32'h8);
    tick;
    chk("fx_ch3_out_ch", {30'd0, fx_och}, 32'd3);
    fx_valid = 4'h0;
    tick;
    tick;

    // External select
    ex_data = 8'b11_10_01_00;
    ex_or = 1'b1;
    exp_q_ex.push_back(4'h5); exp_q_ex.push_back(4'h5);
    ex_valid = 4'b0011;
    ex_sel = 2'd1;
    #1 chk("ex_sel1_in_ready", {28'd0, ex_rdy}, 32'h2);
    tick;
    chk("ex_sel1_out_ch", {30'd0, ex_och}, 32'd1);
    ex_sel = 2'd2;
    #1 chk("ex_sel2_no_grant", {28'd0, ex_rdy}, 32'd0);
    tick;
    chk("ex_sel2_out_valid", {31'd0, ex_ov}, 32'd0);
    ex_sel = 2'd1;
    #1 chk("ex_resel1_in_ready", {28'd0, ex_rdy}, 32'h2);
    tick;
    chk("ex_resel1_out_ch", {30'd0, ex_och}, 32'd1);
    chk("ex_resel1_out_valid", {31'd0, ex_ov}, 32'd1);
    ex_valid = 4'h0;
    tick;

    // External select with NCH=3: index 3 is out of range
    e3_data = 6'b10_01_00;
    e3_or = 1'b1;
    exp_q_e3.push_back(4'ha);
    e3_valid = 3'b111;
    e3_sel = 2'd3;
    #1 chk("e3_sel3_no_grant", {29'd0, e3_rdy}, 32'd0);
    tick;
    chk("e3_sel3_out_valid", {31'd0, e3_ov}, 32'd0);
    e3_sel = 2'd2;
    #1 chk("e3_sel2_in_ready", {29'd0, e3_rdy}, 32'h4);
    tick;
    chk("e3_sel2_out_ch", {30'd0, e3_och}, 32'd2);
    chk("e3_sel2_out_data", {30'd0, e3_od}, 32'd2);
    e3_valid = 3'b000;
    tick;
    tick;

    chk("rr_queue_empty", exp_q_rr.size(), 32'd0);
    chk("fx_queue_empty", exp_q_fx.size(), 32'd0);
    chk("ex_queue_empty", exp_q_ex.size(), 32'd0);
    chk("e3_queue_empty", exp_q_e3.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
